// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the byte-lane data-memory unit
// Contents: access-size encodings, FSM state type, clog2 and lane-count legality helpers.
package dmem_pkg;

  // Access size as log2(bytes).
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit lanes_ok(input int lanes);
    return (lanes == 4) || (lanes == 8);
  endfunction

endpackage

// File: rtl/dmem_lane_rotator.sv
// rtl/dmem_lane_rotator.sv - combinational byte-lane rotate/mask (stores) and un-rotate/extend (loads)
// Ports: off/size/is_unsigned - access offset, clamped log2 size, zero-extend select
//        wdata -> wdata_rot, lane_mask : store data placed on lanes, lanes touched
//        rdata -> rdata_ext            : lane bytes gathered LSB-first and extended
module dmem_lane_rotator import dmem_pkg::*; #(
  parameter int LANES = 4
) (
  input  logic [clog2(LANES)-1:0] off,
  input  logic [1:0]              size,
  input  logic                    is_unsigned,
  input  logic [8*LANES-1:0]      wdata,
  input  logic [8*LANES-1:0]      rdata,
  output logic [LANES-1:0]        lane_mask,
  output logic [8*LANES-1:0]      wdata_rot,
  output logic [8*LANES-1:0]      rdata_ext
);

  localparam int LG = clog2(LANES);

  int              nbytes;
  logic [LG-1:0]   lane;
  logic            fill;

  always_comb begin
    nbytes    = 1 << size;
    lane_mask = '0;
    wdata_rot = '0;
    rdata_ext = '0;
    lane      = '0;
    fill      = 1'b0;
    // Access byte k lives on lane (off+k); the LG-bit add wraps modulo LANES.
    for (int k = 0; k < LANES; k++) begin
      lane = off + LG'(k);
      if (k < nbytes) begin
        lane_mask[lane]         = 1'b1;
        wdata_rot[lane*8 +: 8]  = wdata[k*8 +: 8];
        rdata_ext[k*8 +: 8]     = rdata[lane*8 +: 8];
      end
    end
    // Full-width accesses never reach the fill loop, so is_unsigned is moot there.
    fill = !is_unsigned && rdata_ext[nbytes*8-1];
    for (int k = 0; k < LANES; k++) begin
      if (k >= nbytes) begin
        rdata_ext[k*8 +: 8] = {8{fill}};
      end
    end
  end

endmodule

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane data-memory access unit between load/store stage and LANES byte banks
// Ports: clk, rst (sync, active-high)
//        req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/req_wdata : request
//        rsp_valid/rsp_rdata : one-cycle response pulse, held load data
//        bank_en/bank_we/bank_addr/bank_wdata/bank_rdata : per-lane bank interface
module dmem_lane_unit import dmem_pkg::*; #(
  parameter int LANES   = 4,
  parameter int ADDR_W  = 32,
  parameter int BANK_AW = 10,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [8*LANES-1:0]       req_wdata,
  output logic                     rsp_valid,
  output logic [8*LANES-1:0]       rsp_rdata,
  output logic [LANES-1:0]         bank_en,
  output logic [LANES-1:0]         bank_we,
  output logic [LANES*BANK_AW-1:0] bank_addr,
  output logic [8*LANES-1:0]       bank_wdata,
  input  logic [8*LANES-1:0]       bank_rdata
);

  localparam int         DW     = 8 * LANES;
  localparam int         LG     = clog2(LANES);
  localparam int         CW     = clog2(MEM_LAT + 1);
  localparam logic [1:0] SZ_MAX = (LANES == 8) ? SZ_D : SZ_W;

  generate
    if (!lanes_ok(LANES)) begin : g_lanes_check
      $error("dmem_lane_unit: LANES must be 4 or 8");
    end
  endgenerate

  state_t               state, state_n;
  logic                 accept, capture;
  logic                 we_q, uns_q;
  logic [LG-1:0]        off_q;
  logic [1:0]           size_q;
  logic [CW-1:0]        cnt;

  logic [LG-1:0]        req_off, rot_off;
  logic [BANK_AW-1:0]   base_row;
  logic [1:0]           req_size_c, rot_size;
  logic [LANES-1:0]     lane_mask;
  logic [DW-1:0]        wdata_rot, rdata_ext;
  logic [LANES*BANK_AW-1:0] rows;
  logic                 unused_addr;

  assign req_off     = req_addr[LG-1:0];
  assign base_row    = req_addr[LG +: BANK_AW];
  assign req_size_c  = (req_size > SZ_MAX) ? SZ_MAX : req_size;
  assign unused_addr = ^req_addr[ADDR_W-1:LG+BANK_AW];

  // Store geometry is needed while IDLE (registered into the bank outputs on
  // accept); load extension is needed only in WAIT from the registered request.
  assign rot_off  = (state == ST_IDLE) ? req_off : off_q;
  assign rot_size = (state == ST_IDLE) ? req_size_c : size_q;

  dmem_lane_rotator #(.LANES(LANES)) u_rot (
    .off         (rot_off),
    .size        (rot_size),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .rdata       (bank_rdata),
    .lane_mask   (lane_mask),
    .wdata_rot   (wdata_rot),
    .rdata_ext   (rdata_ext)
  );

  // Lanes below the offset hold the bytes that spilled past the end of the
  // base row, so they address the next row (wrapping silently at the top).
  always_comb begin
    rows = '0;
    for (int j = 0; j < LANES; j++) begin
      if (lane_mask[j]) begin
        rows[j*BANK_AW +: BANK_AW] = base_row + {{(BANK_AW-1){1'b0}}, (LG'(j) < req_off)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      cnt        <= '0;
      rsp_rdata  <= '0;
      bank_en    <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
    end else begin
      // Bank outputs are a one-cycle pulse: set on accept, cleared otherwise.
      bank_en    <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      if (accept) begin
        we_q       <= req_we;
        uns_q      <= req_unsigned;
        off_q      <= req_off;
        size_q     <= req_size_c;
        bank_en    <= lane_mask;
        bank_we    <= req_we ? lane_mask : '0;
        bank_addr  <= rows;
        bank_wdata <= req_we ? wdata_rot : '0;
      end
      if (state == ST_ISSUE) begin
        cnt <= CW'(MEM_LAT - 1);
        if (we_q) rsp_rdata <= '0;
      end
      if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (capture) rsp_rdata <= rdata_ext;
    end
  end

endmodule

// File: tb/tb_dmem_lane_unit.sv
// tb/tb_dmem_lane_unit.sv - self-checking bench for dmem_lane_unit (LANES=4, BANK_AW=10, MEM_LAT=1)
module tb_dmem_lane_unit;

  localparam int LANES   = 4;
  localparam int ADDR_W  = 32;
  localparam int BANK_AW = 10;
  localparam int MEM_LAT = 1;
  localparam int DW      = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid, req_ready, req_we, req_unsigned;
  logic [ADDR_W-1:0]        req_addr;
  logic [1:0]               req_size;
  logic [DW-1:0]            req_wdata;
  logic                     rsp_valid;
  logic [DW-1:0]            rsp_rdata;
  logic [LANES-1:0]         bank_en, bank_we;
  logic [LANES*BANK_AW-1:0] bank_addr;
  logic [DW-1:0]            bank_wdata, bank_rdata;

  always #5 clk = ~clk;

  dmem_lane_unit #(.LANES(LANES), .ADDR_W(ADDR_W), .BANK_AW(BANK_AW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  // Bank RAMs viewed as one flat byte space: lane j, row r is byte r*LANES+j.
  logic [7:0]    ram [4096];
  logic [7:0]    mdl [4096];
  logic [DW-1:0] rd_q = '0;
  assign bank_rdata = rd_q;

  always @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (bank_en[j]) begin
        if (bank_we[j]) ram[{bank_addr[j*BANK_AW +: BANK_AW], 2'(j)}] <= bank_wdata[j*8 +: 8];
        else            rd_q[j*8 +: 8] <= ram[{bank_addr[j*BANK_AW +: BANK_AW], 2'(j)}];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int                     exp_issue_cyc = -1, exp_rsp_cyc = -1, busy_lo = 0, busy_hi = -1;
  logic [LANES-1:0]       e_en, e_we, l_en, l_we;
  logic [LANES*BANK_AW-1:0] e_addr, l_addr;
  logic [DW-1:0]          e_wd, e_rd, l_wd, l_rd;
  int                     l_rsp_cyc = -1;
  bit                     chk_on = 0;

  // Reference: walk the request byte by byte through the flat byte space.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    int n, a, lane, row;
    logic [31:0] v;
    logic s;
    n = (size == 2'd3) ? 4 : (1 << size);
    e_en = '0; e_we = '0; e_addr = '0; e_wd = '0; v = '0;
    for (int k = 0; k < n; k++) begin
      a    = (int'(addr[11:0]) + k) % 4096;
      lane = a % LANES;
      row  = a / LANES;
      e_en[lane] = 1'b1;
      e_addr[lane*BANK_AW +: BANK_AW] = 10'(row);
      if (we) begin
        e_we[lane] = 1'b1;
        e_wd[lane*8 +: 8] = wd[k*8 +: 8];
        mdl[a] = wd[k*8 +: 8];
      end else begin
        v[k*8 +: 8] = mdl[a];
      end
    end
    if (!we && n < 4) begin
      s = !uns && v[n*8-1];
      for (int k = n; k < 4; k++) v[k*8 +: 8] = s ? 8'hFF : 8'h00;
    end
    e_rd = we ? 32'h0 : v;
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("req_ready", 64'(req_ready), (cyc >= busy_lo && cyc <= busy_hi) ? 64'd0 : 64'd1);
      if (cyc == exp_issue_cyc) begin
        chk("bank_en", 64'(bank_en), 64'(e_en));
        chk("bank_we", 64'(bank_we), 64'(e_we));
        chk("bank_addr", 64'(bank_addr), 64'(e_addr));
        chk("bank_wdata", 64'(bank_wdata), 64'(e_wd));
        l_en = bank_en; l_we = bank_we; l_addr = bank_addr; l_wd = bank_wdata;
      end else begin
        chk("bank_quiet", 64'({bank_en, bank_we}), 64'd0);
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(cyc == exp_rsp_cyc));
      if (rsp_valid && cyc == exp_rsp_cyc) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        l_rd = rsp_rdata;
        l_rsp_cyc = cyc;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input bit hold, output int t);
    int g;
    g = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no req_ready expected acceptance within 50 cycles");
      req_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    model(we, addr, size, uns, wd);
    exp_issue_cyc = t + 1;
    exp_rsp_cyc   = t + 2 + (we ? 0 : MEM_LAT);
    busy_lo       = t + 1;
    busy_hi       = exp_rsp_cyc;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (cyc <= exp_rsp_cyc && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no response expected one by cycle %0d", exp_rsp_cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected bench to complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t1, t2;
    logic [31:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      mdl[i] = b;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1;
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_bank_en", 64'(bank_en), 64'd0);
    chk("reset_bank_we", 64'(bank_we), 64'd0);
    chk("reset_bank_addr", 64'(bank_addr), 64'd0);
    chk("reset_bank_wdata", 64'(bank_wdata), 64'd0);

    // Aligned word store.
    do_req(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, t); wait_done();
    chk("sw_we", 64'(l_we), 64'hF);
    chk("sw_rows", 64'(l_addr), 64'({4{10'h040}}));
    chk("sw_wdata", 64'(l_wd), 64'hDEADBEEF);
    chk("sw_rsp", 64'(l_rd), 64'd0);
    chk("sw_latency", 64'(l_rsp_cyc - t), 64'd2);

    // Byte loads, signed and unsigned.
    do_req(1'b1, 32'h103, 2'd0, 1'b0, 32'h80, 1'b0, t); wait_done();
    do_req(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 1'b0, t); wait_done();
    chk("lb_en", 64'(l_en), 64'h8);
    chk("lb_data", 64'(l_rd), 64'hFFFFFF80);
    chk("lb_latency", 64'(l_rsp_cyc - t), 64'd3);
    do_req(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 1'b0, t); wait_done();
    chk("lbu_data", 64'(l_rd), 64'h00000080);

    // Misaligned word load across a row boundary.
    do_req(1'b1, 32'h0FE, 2'd0, 1'b0, 32'h11, 1'b0, t); wait_done();
    do_req(1'b1, 32'h0FF, 2'd0, 1'b0, 32'h22, 1'b0, t); wait_done();
    do_req(1'b1, 32'h100, 2'd0, 1'b0, 32'h33, 1'b0, t); wait_done();
    do_req(1'b1, 32'h101, 2'd0, 1'b0, 32'h44, 1'b0, t); wait_done();
    do_req(1'b0, 32'h0FE, 2'd2, 1'b0, 32'h0, 1'b0, t); wait_done();
    chk("lw_mis_rows", 64'(l_addr), 64'({10'h03F, 10'h03F, 10'h040, 10'h040}));
    chk("lw_mis_data", 64'(l_rd), 64'h44332211);

    // Half store wrapping from the top row to row 0, then read it back.
    do_req(1'b1, 32'hFFF, 2'd1, 1'b0, 32'hA1B2, 1'b0, t); wait_done();
    chk("sh_wrap_we", 64'(l_we), 64'h9);
    chk("sh_wrap_rows", 64'(l_addr), 64'({10'h3FF, 10'h000, 10'h000, 10'h000}));
    chk("sh_wrap_wdata", 64'(l_wd), 64'({8'hB2, 16'h0, 8'hA1}));
    do_req(1'b0, 32'hFFF, 2'd1, 1'b0, 32'h0, 1'b0, t); wait_done();
    chk("lh_wrap_data", 64'(l_rd), 64'hFFFFA1B2);

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b1, t1);
    do_req(1'b0, 32'h0FE, 2'd1, 1'b1, 32'h0, 1'b0, t2);
    wait_done();
    chk("b2b_accept_gap", 64'(t2 - t1), 64'd4);
    chk("b2b_second_rsp", 64'(l_rsp_cyc - t1), 64'd7);

    // Randomized traffic, including size 3 (clamped to word) and wrap area.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFF8 + 12'($urandom_range(0, 7));
      else                           a[11:0] = 12'($urandom_range(0, 255));
      do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, 1'b0, t);
      wait_done();
    end

    // Reset during WAIT drops the response.
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, t);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_issue_cyc = -1; exp_rsp_cyc = -1; busy_hi = -1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", 64'(req_ready), 64'd1);
    chk("rst_wait_bank_en", 64'(bank_en), 64'd0);
    chk("rst_wait_rdata", 64'(rsp_rdata), 64'd0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
